selector_d_sync: RTL and testbench



---
 rtl/selector_d_pkg.sv | 11 +
 rtl/selector_d_mux4.sv | 26 ++
 rtl/selector_d_sync.sv | 57 +++++
 tb/tb_selector_d_sync.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/selector_d_pkg.sv
// Shared constants for the selector_d 4:1 data selector.
package selector_d_pkg;

  localparam int unsigned SELECTOR_D_WIDTH = 4;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

endpackage

// File: rtl/selector_d_mux4.sv
// Purely combinational 4:1 WIDTH-bit multiplexer.
module selector_d_mux4
  import selector_d_pkg::*;
#(
  parameter int unsigned WIDTH = SELECTOR_D_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = in0;
    case (sel)
      SEL_IN0: y = in0;
      SEL_IN1: y = in1;
      SEL_IN2: y = in2;
      SEL_IN3: y = in3;
      default: y = in0;
    endcase
  end

endmodule

// File: rtl/selector_d_sync.sv
// 4:1 data selector with combinational and registered outputs.
// Define SELECTOR_D_PARITY_EN to add the registered parity output par_q.
module selector_d_sync
  import selector_d_pkg::*;
#(
  parameter int unsigned WIDTH = SELECTOR_D_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q
`ifdef SELECTOR_D_PARITY_EN
  ,
  output logic             par_q
`endif
);

  logic [1:0] sel;

  assign sel = {s1, s0};

  selector_d_mux4 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(sel),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .y  (out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      sel_q <= SEL_IN0;
    end else begin
      out_q <= out;
      sel_q <= sel;
    end
  end

`ifdef SELECTOR_D_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^out;
  end
`endif

endmodule

// File: tb/tb_selector_d_sync.sv
// Self-checking bench for selector_d_sync: combinational vector table plus
// a scoreboard for the registered outputs.
module tb_selector_d_sync;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         s0, s1;
  logic [W-1:0] in0, in1, in2, in3;
  logic [W-1:0] out, out_q;
  logic [1:0]   sel_q;
`ifdef SELECTOR_D_PARITY_EN
  logic         par_q;
`endif

  selector_d_sync #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s0   (s0),
    .s1   (s1),
    .in0  (in0),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .out  (out),
    .out_q(out_q),
    .sel_q(sel_q)
`ifdef SELECTOR_D_PARITY_EN
    ,
    .par_q(par_q)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] i0, i1, i2, i3;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [1:0]   sel;
    logic         par;
  } reg_exp_t;

  reg_exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_mux(input logic [1:0] sel);
    logic [W-1:0] r;
    if (sel == 2'b00)      r = in0;
    else if (sel == 2'b01) r = in1;
    else if (sel == 2'b10) r = in2;
    else                   r = in3;
    return r;
  endfunction

  // Push the expected register contents for the coming edge, clock, then compare.
  task automatic tick(input string name);
    reg_exp_t e, g;
    logic [W-1:0] m;
    m = model_mux({s1, s0});
    if (rst) begin
      e.q = '0; e.sel = 2'b00; e.par = 1'b0;
    end else begin
      e.q = m; e.sel = {s1, s0}; e.par = ^m;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk({name, " out_q"}, 8'(out_q), 8'(g.q));
    chk({name, " sel_q"}, 8'(sel_q), 8'(g.sel));
`ifdef SELECTOR_D_PARITY_EN
    chk({name, " par_q"}, 8'(par_q), 8'(g.par));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{2'b00, 4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b0001};
    vecs[1] = '{2'b01, 4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b1010};
    vecs[2] = '{2'b10, 4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b1100};
    vecs[3] = '{2'b11, 4'b0001, 4'b1010, 4'b1100, 4'b1111, 4'b1111};
    vecs[4] = '{2'b11, 4'b1110, 4'b0101, 4'b0011, 4'b1111, 4'b1111};
    vecs[5] = '{2'b00, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0111};
    vecs[6] = '{2'b10, 4'b1111, 4'b1111, 4'b0010, 4'b1111, 4'b0010};
    vecs[7] = '{2'b01, 4'b0000, 4'b1001, 4'b1111, 4'b1111, 4'b1001};

    rst = 1'b1;
    {s1, s0} = 2'b00;
    in0 = 4'b0001; in1 = 4'b1010; in2 = 4'b1100; in3 = 4'b1111;

    for (int i = 0; i < 8; i++) begin
      {s1, s0} = vecs[i].sel;
      in0 = vecs[i].i0; in1 = vecs[i].i1; in2 = vecs[i].i2; in3 = vecs[i].i3;
      #1;
      chk($sformatf("comb vec%0d", i), 8'(out), 8'(vecs[i].exp));
    end

    in0 = 4'b0001; in1 = 4'b1010; in2 = 4'b1100; in3 = 4'b1111;
    rst = 1'b1;
    {s1, s0} = 2'b11;
    tick("reset1");
    tick("reset2");
    chk("out during reset", 8'(out), 8'(4'b1111));

    rst = 1'b0;
    {s1, s0} = 2'b10;
    #1;
    chk("out_q before first edge", 8'(out_q), 8'(4'b0000));
    tick("first capture");

    {s1, s0} = 2'b01;
    tick("select in1");
    in0 = ~in0; #1; chk("in0 toggle", 8'(out), 8'(4'b1010));
    in2 = ~in2; #1; chk("in2 toggle", 8'(out), 8'(4'b1010));
    in3 = ~in3; #1; chk("in3 toggle", 8'(out), 8'(4'b1010));
    in1 = 4'b0110; #1; chk("in1 change", 8'(out), 8'(4'b0110));
    tick("in1 capture");

    in0 = 4'b0001; in2 = 4'b1100; in3 = 4'b1111;
    {s1, s0} = 2'b11;
    tick("select in3");
    rst = 1'b1;
    #1; chk("out with midstream rst", 8'(out), 8'(4'b1111));
    tick("midstream reset");
    rst = 1'b0;
    tick("after midstream reset");

    // Parity sequence: 1111 -> 0, 1010 -> 0, 0001 -> 1.
    in1 = 4'b1010;
    {s1, s0} = 2'b11; tick("par in3");
    {s1, s0} = 2'b01; tick("par in1");
    {s1, s0} = 2'b00; tick("par in0");

    for (int i = 0; i < 24; i++) begin
      {s1, s0} = 2'($urandom_range(0, 3));
      in0 = 4'($urandom); in1 = 4'($urandom);
      in2 = 4'($urandom); in3 = 4'($urandom);
      rst = ($urandom_range(0, 7) == 0);
      #1;
      chk($sformatf("rand comb%0d", i), 8'(out), 8'(model_mux({s1, s0})));
      tick($sformatf("rand%0d", i));
    end

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
